// File: rtl/axi_bram_write_arbiter_if.sv
// AXI4-Lite write-only channel bundle (AW, W, B) used by each slave port of the
// BRAM write arbiter.
interface axi_bram_write_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_bram_write_arbiter.sv
// Two AXI4-Lite write slaves sharing one BRAM write port through a round-robin
// arbiter; one write per cycle, registered BRAM outputs, per-slave B channel.
module axi_bram_write_arbiter #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi_bram_write_arbiter_if.slave      s0_axi,
  axi_bram_write_arbiter_if.slave      s1_axi,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we
);

  localparam int STRB_W   = BRAM_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);

  logic [1:0]                 awvalid;
  logic [1:0]                 wvalid;
  logic [1:0]                 bready;
  logic [1:0]                 req;
  logic [1:0]                 gnt;
  logic                       gnt_idx;
  logic [BRAM_ADDR_WIDTH-1:0] word_addr [2];
  logic [AXI_DATA_WIDTH-1:0]  wdata     [2];
  logic [STRB_W-1:0]          wstrb     [2];

  logic [1:0]                 bvalid_q, bvalid_d;
  logic                       last_q, last_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BRAM_DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [STRB_W-1:0]          we_q, we_d;

  // Only the word-address slice of awaddr reaches the BRAM.
  logic unused_awaddr_bits;
  assign unused_awaddr_bits = ^{s0_axi.awaddr, s1_axi.awaddr};

  assign awvalid      = {s1_axi.awvalid, s0_axi.awvalid};
  assign wvalid       = {s1_axi.wvalid, s0_axi.wvalid};
  assign bready       = {s1_axi.bready, s0_axi.bready};
  assign word_addr[0] = s0_axi.awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
  assign word_addr[1] = s1_axi.awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
  assign wdata[0]     = s0_axi.wdata;
  assign wdata[1]     = s1_axi.wdata;
  assign wstrb[0]     = s0_axi.wstrb;
  assign wstrb[1]     = s1_axi.wstrb;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // A port with an unacknowledged response sits out arbitration.
      assign req[gi] = awvalid[gi] & wvalid[gi] & ~bvalid_q[gi];

      always_comb begin
        bvalid_d[gi] = bvalid_q[gi];
        if (gnt[gi]) begin
          bvalid_d[gi] = 1'b1;
        end else if (bvalid_q[gi] && bready[gi]) begin
          bvalid_d[gi] = 1'b0;
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          bvalid_q[gi] <= 1'b0;
        end else begin
          bvalid_q[gi] <= bvalid_d[gi];
        end
      end
    end
  endgenerate

  // Under contention the port that did not win last time gets the slot.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  assign gnt_idx = gnt[1];

  always_comb begin
    last_d   = last_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    we_d     = '0;
    if (|gnt) begin
      last_d   = gnt_idx;
      addr_d   = word_addr[gnt_idx];
      wrdata_d = wdata[gnt_idx];
      we_d     = wstrb[gnt_idx];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_q   <= 1'b1;
      addr_q   <= '0;
      wrdata_q <= '0;
      we_q     <= '0;
    end else begin
      last_q   <= last_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      we_q     <= we_d;
    end
  end

  assign s0_axi.awready = gnt[0];
  assign s0_axi.wready  = gnt[0];
  assign s0_axi.bresp   = 2'b00;
  assign s0_axi.bvalid  = bvalid_q[0];
  assign s1_axi.awready = gnt[1];
  assign s1_axi.wready  = gnt[1];
  assign s1_axi.bresp   = 2'b00;
  assign s1_axi.bvalid  = bvalid_q[1];

  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = ~aresetn;
  assign bram_porta_addr   = addr_q;
  assign bram_porta_wrdata = wrdata_q;
  assign bram_porta_we     = we_q;

endmodule

// File: tb/tb_axi_bram_write_arbiter.sv
// Scoreboard bench for axi_bram_write_arbiter: a reference model predicts grants
// and the BRAM/response state after each edge; a monitor pops and compares.
module tb_axi_bram_write_arbiter;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  axi_bram_write_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axi_bram_write_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();

  logic        porta_clk;
  logic        porta_rst;
  logic [9:0]  porta_addr;
  logic [31:0] porta_wrdata;
  logic [3:0]  porta_we;

  axi_bram_write_arbiter dut (
    .aclk              (clk),
    .aresetn           (aresetn),
    .s0_axi            (s0_if),
    .s1_axi            (s1_if),
    .bram_porta_clk    (porta_clk),
    .bram_porta_rst    (porta_rst),
    .bram_porta_addr   (porta_addr),
    .bram_porta_wrdata (porta_wrdata),
    .bram_porta_we     (porta_we)
  );

  logic [31:0] awaddr_t [2];
  logic [31:0] wdata_t  [2];
  logic [3:0]  wstrb_t  [2];
  logic        aw_t     [2];
  logic        w_t      [2];
  logic        br_t     [2];

  assign s0_if.awaddr  = awaddr_t[0];
  assign s0_if.awvalid = aw_t[0];
  assign s0_if.wdata   = wdata_t[0];
  assign s0_if.wstrb   = wstrb_t[0];
  assign s0_if.wvalid  = w_t[0];
  assign s0_if.bready  = br_t[0];
  assign s1_if.awaddr  = awaddr_t[1];
  assign s1_if.awvalid = aw_t[1];
  assign s1_if.wdata   = wdata_t[1];
  assign s1_if.wstrb   = wstrb_t[1];
  assign s1_if.wvalid  = w_t[1];
  assign s1_if.bready  = br_t[1];

  typedef struct packed {
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        b0;
    logic        b1;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: who won last, outstanding responses, last BRAM word written.
  bit          last_m;
  bit          mb [2];
  logic [9:0]  maddr;
  logic [31:0] mdata;
  int          last_grant;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    last_m     = 1'b1;
    mb[0]      = 1'b0;
    mb[1]      = 1'b0;
    maddr      = '0;
    mdata      = '0;
    last_grant = -1;
  endtask

  task automatic new_txn(input int n, input logic [3:0] strb);
    awaddr_t[n] = $urandom;
    wdata_t[n]  = $urandom;
    wstrb_t[n]  = strb;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit   rq [2];
    int   g;
    exp_t e;
    #1;
    for (int n = 0; n < 2; n++) rq[n] = aw_t[n] && w_t[n] && !mb[n];
    if (rq[0] && rq[1]) g = last_m ? 0 : 1;
    else if (rq[0])     g = 0;
    else if (rq[1])     g = 1;
    else                g = -1;
    check("ready", 64'({s0_if.awready, s0_if.wready, s1_if.awready, s1_if.wready,
                        s0_if.bresp, s1_if.bresp}),
                   64'({g == 0, g == 0, g == 1, g == 1, 4'b0000}));
    for (int n = 0; n < 2; n++) if (mb[n] && br_t[n]) mb[n] = 1'b0;
    e.we = 4'h0;
    if (g >= 0) begin
      mb[g]  = 1'b1;
      last_m = (g == 1);
      maddr  = 10'((awaddr_t[g] / 4) % 1024);
      mdata  = wdata_t[g];
      e.we   = wstrb_t[g];
    end
    e.addr = maddr;
    e.data = mdata;
    e.b0   = mb[0];
    e.b1   = mb[1];
    exp_q.push_back(e);
    last_grant = g;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bram", 64'({porta_we, porta_addr, porta_wrdata, s0_if.bvalid, s1_if.bvalid}),
                      64'(e));
      end
    end
  end

  task automatic idle(input int cycles);
    for (int n = 0; n < 2; n++) begin
      aw_t[n] = 1'b0;
      w_t[n]  = 1'b0;
      br_t[n] = 1'b1;
    end
    repeat (cycles) cycle();
  endtask

  initial begin : stim
    bit stalled;
    for (int n = 0; n < 2; n++) begin
      new_txn(n, 4'hF);
      aw_t[n] = 1'b1;
      w_t[n]  = 1'b1;
      br_t[n] = 1'b1;
    end
    model_reset();

    // Reset held with both ports requesting.
    repeat (3) @(posedge clk);
    #2;
    check("rst_we", 64'(porta_we), 64'(0));
    check("rst_addr_data", 64'({porta_addr, porta_wrdata}), 64'(0));
    check("rst_bvalid", 64'({s0_if.bvalid, s1_if.bvalid}), 64'(0));
    check("rst_porta_rst", 64'(porta_rst), 64'(1));
    check("rst_ready", 64'({s0_if.awready, s1_if.awready}), 64'(2'b10));
    @(negedge clk);
    aresetn = 1'b1;

    // Contention: grants alternate starting with port 0.
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("contention_grant", 64'(last_grant), 64'(i % 2));
      if (last_grant >= 0) new_txn(last_grant, 4'(i + 1));
    end
    check("porta_rst_run", 64'(porta_rst), 64'(0));
    idle(2);

    // Single write from s0.
    awaddr_t[0] = 32'h0000_0FFC;
    wdata_t[0]  = 32'hDEADBEEF;
    wstrb_t[0]  = 4'hF;
    aw_t[0] = 1'b1;
    w_t[0]  = 1'b1;
    cycle();
    check("single_word", 64'({porta_addr, porta_wrdata, porta_we, s0_if.bvalid}),
                         64'({10'h3FF, 32'hDEADBEEF, 4'hF, 1'b1}));
    idle(2);

    // Backpressure on s1 after its first write.
    stalled = 1'b0;
    for (int n = 0; n < 2; n++) begin
      new_txn(n, 4'hF);
      aw_t[n] = 1'b1;
      w_t[n]  = 1'b1;
    end
    for (int i = 0; i < 14; i++) begin
      if (i == 10) br_t[1] = 1'b1;
      cycle();
      if (stalled && i < 10) check("bp_bvalid1", 64'(s1_if.bvalid), 64'(1));
      if (last_grant == 1 && !stalled) begin
        stalled = 1'b1;
        br_t[1] = 1'b0;
      end
      if (last_grant >= 0) new_txn(last_grant, 4'hF);
    end
    idle(3);

    // Partial and empty strobes on s1.
    awaddr_t[1] = 32'h0000_0008;
    wdata_t[1]  = 32'h1234_5678;
    wstrb_t[1]  = 4'h3;
    aw_t[1] = 1'b1;
    w_t[1]  = 1'b1;
    cycle();
    check("partial_strb", 64'({porta_we, porta_addr}), 64'({4'h3, 10'h002}));
    idle(1);
    awaddr_t[1] = 32'h0000_0010;
    wstrb_t[1]  = 4'h0;
    aw_t[1] = 1'b1;
    w_t[1]  = 1'b1;
    cycle();
    check("zero_strb", 64'({porta_we, s1_if.bvalid}), 64'({4'h0, 1'b1}));
    idle(2);

    // Randomized traffic with independent AW/W arrival and random bready.
    last_grant = -1;
    for (int i = 0; i < 1500; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (last_grant == n) begin
          aw_t[n] = 1'b0;
          w_t[n]  = 1'b0;
        end
        if (!aw_t[n] && $urandom_range(0, 1) == 1) begin
          awaddr_t[n] = $urandom;
          aw_t[n]     = 1'b1;
        end
        if (!w_t[n] && $urandom_range(0, 1) == 1) begin
          wdata_t[n] = $urandom;
          wstrb_t[n] = 4'($urandom_range(0, 15));
          w_t[n]     = 1'b1;
        end
        br_t[n] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    idle(3);

    // Asynchronous reset while a write and a response are in flight.
    awaddr_t[0] = 32'h0000_0040;
    wdata_t[0]  = 32'hCAFE_F00D;
    wstrb_t[0]  = 4'hF;
    aw_t[0] = 1'b1;
    w_t[0]  = 1'b1;
    cycle();
    aw_t[0] = 1'b0;
    w_t[0]  = 1'b0;
    check("pre_arst", 64'({porta_we, s0_if.bvalid}), 64'({4'hF, 1'b1}));
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_clear", 64'({porta_we, s0_if.bvalid, porta_addr, porta_wrdata}), 64'(0));
    exp_q.delete();
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
    idle(3);

    @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_bram_write_arbiter.md
# axi_bram_write_arbiter

Shares one BRAM write port (port A) between two AXI4-Lite write-only slaves, so that two independent masters can fill the same BRAM, for example a PS master and a PL sequencer. A round-robin arbiter grants at most one write per cycle. The BRAM port outputs are registered, which gives one cycle of write latency. Each slave keeps its own write-response channel.

## Interface
- AXI_DATA_WIDTH, 32: data width of both slaves; equals BRAM_DATA_WIDTH.
- AXI_ADDR_WIDTH, 32: address width of both slaves.
- BRAM_DATA_WIDTH, 32: BRAM word width.
- BRAM_ADDR_WIDTH, 10: BRAM word-address width.
- aclk  in  1  single clock; all logic on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- sN_axi_awaddr  in  AXI_ADDR_WIDTH  write address, N = 0 and 1.
- sN_axi_awvalid  in  1  address valid.
- sN_axi_awready  out  1  address accepted.
- sN_axi_wdata  in  AXI_DATA_WIDTH  write data.
- sN_axi_wstrb  in  AXI_DATA_WIDTH/8  byte strobes.
- sN_axi_wvalid  in  1  data valid.
- sN_axi_wready  out  1  data accepted.
- sN_axi_bresp  out  2  constant 2'd0 (OKAY).
- sN_axi_bvalid  out  1  response valid.
- sN_axi_bready  in  1  response accepted.
- bram_porta_clk  out  1  equals aclk.
- bram_porta_rst  out  1  equals ~aresetn.
- bram_porta_addr  out  BRAM_ADDR_WIDTH  registered word address.
- bram_porta_wrdata  out  BRAM_DATA_WIDTH  registered write data.
- bram_porta_we  out  BRAM_DATA_WIDTH/8  registered byte write enables.

## Operation
- ADDR_LSB = clogb2(AXI_DATA_WIDTH/8 - 1). The word address is awaddr[ADDR_LSB+BRAM_ADDR_WIDTH-1:ADDR_LSB].
- Request: reqN = sN_awvalid & sN_wvalid & ~bvalidN.
  - awvalid without wvalid, or wvalid without awvalid, is not a request.
  - A port with a pending response does not request.
- Arbitration is combinational on reqN. It uses a 1-bit register last (index of the last granted port).
  - Only one port requests: that port is granted.
  - Both request: port ~last is granted.
  - No request: no grant, and last holds.
- Grant to port N, in the same cycle:
  - sN_awready = sN_wready = 1.
  - The other port's ready signals are 0.
  - Ready signals are 0 whenever there is no grant.
- Rising edge after a grant to port N:
  - last <= N.
  - bram_porta_addr <= word address of port N.
  - bram_porta_wrdata <= sN_wdata.
  - bram_porta_we <= sN_wstrb.
  - bvalidN <= 1.
- Rising edge with no grant: bram_porta_we <= 0. addr and wrdata hold their values.
- bvalidN clears on the edge where bvalidN & sN_bready is high. The port may request again from the following cycle.
- wstrb = 0 is still a granted write. It produces we = 0 and bvalid = 1.

## Timing
- Reset values (asynchronous, immediate on aresetn low):
  - bvalid0 = bvalid1 = 0.
  - bram_porta_we = 0, bram_porta_addr = 0, bram_porta_wrdata = 0.
  - last = 1, so port 0 wins the first contention.
  - Ready outputs follow the combinational rules and are 0 unless a request is present.
- Reset mid-transaction: a write registered for the BRAM in the same cycle is dropped (we forced to 0). A pending bvalid is lost. The masters are reset alongside this block.
- Latency:
  - Grant in cycle T.
  - BRAM write strobe in cycle T+1.
  - bvalid high from T+1.
- Throughput:
  - A single port with bready held high writes once every 2 cycles: grant, then response, then eligible again.
  - Both ports with bready held high alternate and reach one write per cycle.
- A port stalled on bready = 0 never blocks the other port.
- No combinational path from bready to any ready output within the same cycle. Ready depends only on valid signals and registers.

## Test plan
- Reset: hold aresetn = 0 with both ports driving valid. Required: we = 0, bvalid0 = bvalid1 = 0, addr = 0. After release, port 0 is granted first.
- Single write: s0 awaddr = 0x0000_0FFC, wdata = 0xDEADBEEF, wstrb = 0xF. Required:
  - awready0/wready0 high in cycle T.
  - In T+1: addr = 0x3FF, wrdata = 0xDEADBEEF, we = 0xF, bvalid0 = 1.
- Contention: both ports request continuously with bready held high. Required: grants alternate 0,1,0,1 and we is nonzero every cycle after the first.
- Backpressure: s1 bready = 0 after its first write. Required:
  - bvalid1 stays high and s1 receives no further grants.
  - s0 writes every other cycle.
  - After bready1 = 1, s1 resumes.
- Partial strobe: s1 wstrb = 0x3 at address 0x8. Required: we = 0x3 and addr = 0x2. A wstrb = 0x0 write gives we = 0 with bvalid1 = 1.
- Async reset: assert aresetn low mid-cycle while bvalid0 = 1 and we = 0xF. Required: both clear before the next clock edge.
